// File: rtl/uart_host_mem_arbiter.sv
// Shares the instr/data memory port between UART host packets and the CPU.
// Host always wins; read results are streamed back MSB-first, one byte per TX slot.
module uart_host_mem_arbiter #(
  parameter int ADDR_BITS = 9,
  parameter int DATA_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pkt_valid,
  input  logic                 pkt_rw,
  input  logic                 pkt_mem_sel,
  input  logic [ADDR_BITS-1:0] pkt_addr,
  input  logic [DATA_W-1:0]    pkt_wdata,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic                 cpu_sel,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [DATA_W-1:0]    cpu_wdata,
  output logic                 cpu_stall,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic                 mem_sel,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 tx_start,
  output logic [7:0]           tx_byte,
  input  logic                 tx_busy,
  output logic                 overflow
);

  typedef enum logic [2:0] {
    IDLE, WRITE, READ, RWAIT, TXWAIT, TXSTART, TXGUARD
  } state_t;

  state_t               state, state_nxt;
  logic                 pend_valid, pend_rw, pend_sel;
  logic [ADDR_BITS-1:0] pend_addr;
  logic [DATA_W-1:0]    pend_wdata;
  logic                 op_sel;
  logic [ADDR_BITS-1:0] op_addr;
  logic [DATA_W-1:0]    op_wdata;
  logic [DATA_W-1:0]    rdata_q;
  logic [1:0]           byte_cnt;
  logic                 consume;

  assign consume   = (state == IDLE) && pend_valid;
  assign cpu_stall = (state != IDLE) || pend_valid;

  // A packet arriving on the cycle the buffer drains takes the freed slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_rw    <= 1'b0;
      pend_sel   <= 1'b0;
      pend_addr  <= '0;
      pend_wdata <= '0;
      overflow   <= 1'b0;
    end else begin
      if (pkt_valid && (!pend_valid || consume)) begin
        pend_valid <= 1'b1;
        pend_rw    <= pkt_rw;
        pend_sel   <= pkt_mem_sel;
        pend_addr  <= pkt_addr;
        pend_wdata <= pkt_wdata;
      end else if (consume) begin
        pend_valid <= 1'b0;
      end
      if (pkt_valid && pend_valid && !consume)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_sel   <= 1'b0;
      op_addr  <= '0;
      op_wdata <= '0;
      rdata_q  <= '0;
      byte_cnt <= 2'd0;
    end else begin
      state <= state_nxt;
      if (consume) begin
        op_sel   <= pend_sel;
        op_addr  <= pend_addr;
        op_wdata <= pend_wdata;
      end
      if (state == RWAIT) begin
        rdata_q  <= mem_rdata;
        byte_cnt <= 2'd0;
      end else if (state == TXGUARD && byte_cnt != 2'd3) begin
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_sel   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    tx_start  = 1'b0;
    tx_byte   = 8'd0;
    case (state)
      IDLE: begin
        if (pend_valid) begin
          state_nxt = pend_rw ? WRITE : READ;
        end else begin
          mem_en    = cpu_req;
          mem_we    = cpu_we;
          mem_sel   = cpu_sel;
          mem_addr  = cpu_addr;
          mem_wdata = cpu_wdata;
        end
      end
      WRITE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_sel   = op_sel;
        mem_addr  = op_addr;
        mem_wdata = op_wdata;
        state_nxt = IDLE;
      end
      READ: begin
        mem_en    = 1'b1;
        mem_sel   = op_sel;
        mem_addr  = op_addr;
        state_nxt = RWAIT;
      end
      RWAIT:   state_nxt = TXWAIT;
      TXWAIT:  if (!tx_busy) state_nxt = TXSTART;
      TXSTART: begin
        tx_start = 1'b1;
        case (byte_cnt)
          2'd0:    tx_byte = rdata_q[31:24];
          2'd1:    tx_byte = rdata_q[23:16];
          2'd2:    tx_byte = rdata_q[15:8];
          default: tx_byte = rdata_q[7:0];
        endcase
        state_nxt = TXGUARD;
      end
      // The transmitter's busy flag lags tx_start by a cycle, so it is not trusted here.
      TXGUARD: state_nxt = (byte_cnt == 2'd3) ? IDLE : TXWAIT;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_host_mem_arbiter.sv
// Bench for uart_host_mem_arbiter: behavioural memory + UART TX environment,
// with a packet-level reference model predicting memory accesses and returned bytes.
module tb_uart_host_mem_arbiter;
  localparam int AB = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pkt_valid = 1'b0, pkt_rw = 1'b0, pkt_mem_sel = 1'b0;
  logic [AB-1:0] pkt_addr = '0;
  logic [DW-1:0] pkt_wdata = '0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0, cpu_sel = 1'b0;
  logic [AB-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_stall, mem_en, mem_we, mem_sel;
  logic [AB-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          tx_start;
  logic [7:0]    tx_byte;
  logic          tx_busy;
  logic          overflow;

  int pass_cnt = 0;
  int total_cnt = 0;
  int busy_cnt = 0;
  int busy_viol = 0;

  logic [31:0] env_mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [42:0] acc_log[$], exp_acc[$];
  logic [7:0]  tx_log[$], exp_tx[$];

  always #5 clk = ~clk;

  uart_host_mem_arbiter #(.ADDR_BITS(AB), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .pkt_valid(pkt_valid), .pkt_rw(pkt_rw), .pkt_mem_sel(pkt_mem_sel),
    .pkt_addr(pkt_addr), .pkt_wdata(pkt_wdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_sel(cpu_sel),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .tx_start(tx_start), .tx_byte(tx_byte), .tx_busy(tx_busy), .overflow(overflow)
  );

  // Environment: memory with 1-cycle read latency, transmitter busy for 3..6 cycles per byte.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) env_mem[{mem_sel, mem_addr}] <= mem_wdata;
      else        mem_rdata <= env_mem[{mem_sel, mem_addr}];
    end
    if (tx_start)          busy_cnt <= $urandom_range(3, 6);
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // Host accesses are the ones made while the CPU is held off.
  always @(negedge clk) begin
    if (rst_n && mem_en && cpu_stall)
      acc_log.push_back({mem_we, mem_sel, mem_addr, mem_we ? mem_wdata : 32'h0});
    if (tx_start) begin
      tx_log.push_back(tx_byte);
      if (tx_busy) busy_viol++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_pkt(input logic rw, input logic sel,
                                    input logic [AB-1:0] addr, input logic [DW-1:0] wd);
    int idx;
    logic [31:0] v;
    idx = int'({sel, addr});
    if (rw) begin
      exp_acc.push_back({1'b1, sel, addr, wd});
      ref_mem[idx] = wd;
    end else begin
      exp_acc.push_back({1'b0, sel, addr, 32'h0});
      v = ref_mem[idx];
      for (int b = 0; b < 4; b++) exp_tx.push_back(8'(v >> (24 - 8 * b)));
    end
  endfunction

  task automatic drive_pkt(input logic rw, input logic sel,
                           input logic [AB-1:0] addr, input logic [DW-1:0] wd);
    pkt_valid = 1'b1; pkt_rw = rw; pkt_mem_sel = sel; pkt_addr = addr; pkt_wdata = wd;
    @(posedge clk); #1;
  endtask

  task automatic send_pkt(input logic rw, input logic sel,
                          input logic [AB-1:0] addr, input logic [DW-1:0] wd);
    drive_pkt(rw, sel, addr, wd);
    pkt_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!cpu_stall) break;
    end
    if (i == budget) begin
      total_cnt++;
      $display("FAIL %s_idle_timeout: cpu_stall still %b after %0d cycles, want 0", name, cpu_stall, budget);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_tx(input string name, input int n, input int budget);
    for (int i = 0; i < budget && tx_log.size() < n; i++) @(negedge clk);
    if (tx_log.size() < n) begin
      total_cnt++;
      $display("FAIL %s_tx_timeout: got %0d bytes, want %0d", name, tx_log.size(), n);
    end
  endtask

  task automatic check_logs(input string name);
    int n;
    total_cnt++;
    if (acc_log.size() !== exp_acc.size())
      $display("FAIL %s_acc_count: got %0d, want %0d", name, acc_log.size(), exp_acc.size());
    else pass_cnt++;
    n = (acc_log.size() < exp_acc.size()) ? acc_log.size() : exp_acc.size();
    for (int i = 0; i < n; i++) begin
      total_cnt++;
      if (acc_log[i] !== exp_acc[i])
        $display("FAIL %s_acc[%0d]: got %h, want %h", name, i, acc_log[i], exp_acc[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (tx_log.size() !== exp_tx.size())
      $display("FAIL %s_tx_count: got %0d, want %0d", name, tx_log.size(), exp_tx.size());
    else pass_cnt++;
    n = (tx_log.size() < exp_tx.size()) ? tx_log.size() : exp_tx.size();
    for (int i = 0; i < n; i++) begin
      total_cnt++;
      if (tx_log[i] !== exp_tx[i])
        $display("FAIL %s_tx[%0d]: got %h, want %h", name, i, tx_log[i], exp_tx[i]);
      else pass_cnt++;
    end
    acc_log.delete(); exp_acc.delete(); tx_log.delete(); exp_tx.delete();
  endtask

  task automatic test_reset();
    logic [43:0] got;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    got = {cpu_stall, mem_en, mem_we, mem_sel, mem_addr, mem_wdata};
    total_cnt++;
    if (got !== 44'h0) $display("FAIL reset_mem_port: got %h, want 0", got);
    else pass_cnt++;
    total_cnt++;
    if ({tx_start, tx_byte} !== 9'h0) $display("FAIL reset_tx: got %h, want 0", {tx_start, tx_byte});
    else pass_cnt++;
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b, want 0", overflow);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    acc_log.delete(); tx_log.delete(); exp_acc.delete(); exp_tx.delete();
  endtask

  task automatic test_write();
    model_pkt(1'b1, 1'b1, 9'h005, 32'hDEADBEEF);
    send_pkt(1'b1, 1'b1, 9'h005, 32'hDEADBEEF);
    @(negedge clk);
    total_cnt++;
    if ({cpu_stall, mem_en} !== 2'b10) $display("FAIL write_n1: stall,en got %b, want 10", {cpu_stall, mem_en});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({cpu_stall, mem_en, mem_we, mem_sel} !== 4'b1111)
      $display("FAIL write_n2_ctrl: got %b, want 1111", {cpu_stall, mem_en, mem_we, mem_sel});
    else pass_cnt++;
    total_cnt++;
    if ({mem_addr, mem_wdata} !== {9'h005, 32'hDEADBEEF})
      $display("FAIL write_n2_addr_data: got %h %h, want 005 deadbeef", mem_addr, mem_wdata);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({cpu_stall, mem_en} !== 2'b00) $display("FAIL write_n3: stall,en got %b, want 00", {cpu_stall, mem_en});
    else pass_cnt++;
    @(posedge clk); #1;
    check_logs("write");
  endtask

  task automatic test_read();
    logic [7:0] want [4];
    want = '{8'h12, 8'h34, 8'h56, 8'h78};
    env_mem[10'h010] = 32'h12345678;
    ref_mem[10'h010] = 32'h12345678;
    model_pkt(1'b0, 1'b0, 9'h010, 32'h0);
    send_pkt(1'b0, 1'b0, 9'h010, 32'hFFFFFFFF);
    wait_idle("read", 200);
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (tx_log.size() <= i) $display("FAIL read_byte%0d: missing, want %h", i, want[i]);
      else if (tx_log[i] !== want[i]) $display("FAIL read_byte%0d: got %h, want %h", i, tx_log[i], want[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (busy_viol !== 0) $display("FAIL read_start_while_busy: got %0d, want 0", busy_viol);
    else pass_cnt++;
    check_logs("read");
  endtask

  task automatic test_cpu_passthrough(input int iters);
    for (int i = 0; i < iters; i++) begin
      if (i == 0) begin
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_sel = 1'b0; cpu_addr = 9'h003;
      end else begin
        cpu_req = 1'($urandom); cpu_we = 1'($urandom); cpu_sel = 1'($urandom);
        cpu_addr = 9'($urandom_range(0, 15));
      end
      cpu_wdata = $urandom;
      @(negedge clk);
      total_cnt++;
      if ({mem_en, mem_we, mem_sel, mem_addr, mem_wdata} !== {cpu_req, cpu_we, cpu_sel, cpu_addr, cpu_wdata})
        $display("FAIL cpu_mirror%0d: got %b%b%b %h %h, want %b%b%b %h %h", i, mem_en, mem_we, mem_sel,
                 mem_addr, mem_wdata, cpu_req, cpu_we, cpu_sel, cpu_addr, cpu_wdata);
      else pass_cnt++;
      total_cnt++;
      if (cpu_stall !== 1'b0) $display("FAIL cpu_stall%0d: got %b, want 0", i, cpu_stall);
      else pass_cnt++;
      if (cpu_req && cpu_we) ref_mem[{cpu_sel, cpu_addr}] = cpu_wdata;
      @(posedge clk); #1;
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    check_logs("cpu");
  endtask

  task automatic test_same_cycle();
    model_pkt(1'b1, 1'b0, 9'h007, 32'h11112222);
    model_pkt(1'b1, 1'b1, 9'h008, 32'h33334444);
    drive_pkt(1'b1, 1'b0, 9'h007, 32'h11112222);
    send_pkt(1'b1, 1'b1, 9'h008, 32'h33334444);
    wait_idle("same_cycle", 50);
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL same_cycle_overflow: got %b, want 0", overflow);
    else pass_cnt++;
    check_logs("same_cycle");
  endtask

  task automatic test_random(input int iters);
    logic rw, sel;
    logic [AB-1:0] addr;
    logic [DW-1:0] wd;
    busy_viol = 0;
    for (int i = 0; i < iters; i++) begin
      test_cpu_passthrough($urandom_range(1, 3));
      rw = 1'($urandom); sel = 1'($urandom);
      addr = 9'($urandom_range(0, 15)); wd = $urandom;
      model_pkt(rw, sel, addr, wd);
      send_pkt(rw, sel, addr, wd);
      wait_idle("random", 300);
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
      check_logs("random");
    end
    total_cnt++;
    if (busy_viol !== 0) $display("FAIL random_start_while_busy: got %0d, want 0", busy_viol);
    else pass_cnt++;
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL random_overflow: got %b, want 0", overflow);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    model_pkt(1'b0, 1'b1, 9'h020, 32'h0);
    send_pkt(1'b0, 1'b1, 9'h020, 32'h0);
    wait_tx("b2b", 1, 100);
    @(posedge clk); #1;
    model_pkt(1'b1, 1'b0, 9'h021, 32'hCAFEF00D);
    drive_pkt(1'b1, 1'b0, 9'h021, 32'hCAFEF00D);
    send_pkt(1'b1, 1'b0, 9'h022, 32'hBADC0DE5);
    wait_idle("b2b", 300);
    total_cnt++;
    if (overflow !== 1'b1) $display("FAIL b2b_overflow: got %b, want 1", overflow);
    else pass_cnt++;
    check_logs("b2b");
  endtask

  task automatic test_reset_mid_tx();
    send_pkt(1'b0, 1'b0, 9'h010, 32'h0);
    wait_tx("rst_mid", 1, 100);
    @(posedge clk); #1;
    send_pkt(1'b1, 1'b0, 9'h030, 32'h55555555);
    acc_log.delete(); tx_log.delete(); exp_acc.delete(); exp_tx.delete();
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({cpu_stall, tx_start, mem_en, overflow} !== 4'b0000)
      $display("FAIL rst_mid_outputs: stall,start,en,ovf got %b, want 0000", {cpu_stall, tx_start, mem_en, overflow});
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    total_cnt++;
    if (tx_log.size() !== 0) $display("FAIL rst_mid_tx_after: got %0d bytes, want 0", tx_log.size());
    else pass_cnt++;
    total_cnt++;
    if (acc_log.size() !== 0) $display("FAIL rst_mid_acc_after: got %0d accesses, want 0", acc_log.size());
    else pass_cnt++;
    total_cnt++;
    if (cpu_stall !== 1'b0) $display("FAIL rst_mid_stall_after: got %b, want 0", cpu_stall);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      env_mem[i] = 32'(i) * 32'h9E3779B1 + 32'h00C0FFEE;
      ref_mem[i] = 32'(i) * 32'h9E3779B1 + 32'h00C0FFEE;
    end
    test_reset();
    test_write();
    test_read();
    test_cpu_passthrough(6);
    test_same_cycle();
    test_random(24);
    test_back_to_back();
    test_reset_mid_tx();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
